// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 icodes, status codes, pipeline-register field offsets and the writeback bubble
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  typedef enum logic [1:0] {S_AOK = 2'd0, S_HLT = 2'd1, S_ADR = 2'd2, S_INS = 2'd3} stat_t;

  typedef enum logic {H_IDLE = 1'b0, H_WAIT = 1'b1} hs_state_t;

  localparam int MR_W     = 145;
  localparam int MR_BAD   = 144;
  localparam int MR_ICODE = 140;
  localparam int MR_VALE  = 72;
  localparam int MR_VALA  = 8;
  localparam int MR_DSTE  = 4;
  localparam int MR_DSTM  = 0;

  localparam int WR_W     = 142;
  localparam int WR_STAT  = 140;
  localparam int WR_ICODE = 136;
  localparam int WR_VALE  = 72;
  localparam int WR_VALM  = 8;
  localparam int WR_DSTE  = 4;
  localparam int WR_DSTM  = 0;

  localparam logic [WR_W-1:0] WR_BUBBLE = {S_AOK, I_NOP, 64'd0, 64'd0, 4'hf, 4'hf};

  function automatic logic [WR_W-1:0] make_wr(input stat_t s, input logic [3:0] ic,
                                               input logic [63:0] ve, input logic [63:0] vm,
                                               input logic [3:0] de, input logic [3:0] dm);
    return {s, ic, ve, vm, de, dm};
  endfunction

endpackage

// File: rtl/dmem_handshake.sv
// dmem_handshake: IDLE/WAIT request FSM with timeout counter and registered dmem_* outputs
module dmem_handshake
  import y86_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        ack,
  output logic        req,
  output logic        req_we,
  output logic [63:0] req_addr,
  output logic [63:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  hs_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic req_q, req_d, we_q, we_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d;

  // state, counter and request registers; reset drops the request at once
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= H_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end

  // leave WAIT on ack or on the terminal count; ack is tested first so it wins a tie
  always_comb
    state_d = (state_q == H_IDLE) ? (start ? H_WAIT : H_IDLE)
                                  : ((ack || cnt_q == TERM) ? H_IDLE : H_WAIT);

  // completion flags and next values of the registered request fields
  always_comb begin
    busy    = state_q == H_WAIT;
    done    = busy && ack;
    timeout = busy && !ack && cnt_q == TERM;
    req_d   = state_d == H_WAIT;
    cnt_d   = (busy && state_d == H_WAIT) ? cnt_q + 1'b1 : '0;
    we_d    = start ? we : we_q;
    addr_d  = start ? addr : addr_q;
    wdata_d = start ? wdata : wdata_q;
  end

  assign req       = req_q;
  assign req_we    = we_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;

endmodule

// File: rtl/memory_stage.sv
// memory_stage: Y86 M stage with handshaked data memory; MEM_ALIGN_CHECK_EN adds a misaligned-access ADR check
module memory_stage
  import y86_pkg::*;
#(
  parameter int ADDR_LIMIT = 4096,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MR_W-1:0]   memory_reg,
  output logic              m_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [63:0]       dmem_addr,
  output logic [63:0]       dmem_wdata,
  input  logic [63:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [63:0]       m_valM,
  output logic [3:0]        m_dstM,
  output logic              m_status,
  output logic [WR_W-1:0]   write_reg
);

  logic bad, rd, wr, acc, addr_err, halted, start, busy, done, timeout;
  logic [3:0] icode, dst_e, dst_m;
  logic [63:0] val_e, val_a, addr;
  logic unused_cnd;
  stat_t stat_in;
  logic [WR_W-1:0] write_reg_q, write_reg_d;
  logic [63:0] m_valm_q, m_valm_d;
  logic [3:0] m_dstm_q, m_dstm_d;
  logic m_status_q, m_status_d;

  assign bad        = memory_reg[MR_BAD];
  assign icode      = memory_reg[MR_ICODE+:4];
  assign val_e      = memory_reg[MR_VALE+:64];
  assign val_a      = memory_reg[MR_VALA+:64];
  assign dst_e      = memory_reg[MR_DSTE+:4];
  assign dst_m      = memory_reg[MR_DSTM+:4];
  assign unused_cnd = ^memory_reg[139:136];

  assign rd   = icode == I_MRMOVQ || icode == I_POPQ || icode == I_RET;
  assign wr   = icode == I_RMMOVQ || icode == I_CALL || icode == I_PUSHQ;
  assign acc  = rd || wr;
  assign addr = (icode == I_RET || icode == I_POPQ) ? val_a : val_e;

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err = addr > 64'(ADDR_LIMIT - 8) || addr[2:0] != 3'd0;
`else
  assign addr_err = addr > 64'(ADDR_LIMIT - 8);
`endif

  assign stat_in = bad ? S_INS : (icode == I_HALT) ? S_HLT : (acc && addr_err) ? S_ADR : S_AOK;
  assign halted  = write_reg_q[WR_STAT+:2] != S_AOK;
  assign start   = !halted && !busy && acc && stat_in == S_AOK;
  assign m_stall = busy ? !dmem_ack : start;

  dmem_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .we        (wr),
    .addr      (addr),
    .wdata     (val_a),
    .ack       (dmem_ack),
    .req       (dmem_req),
    .req_we    (dmem_we),
    .req_addr  (dmem_addr),
    .req_wdata (dmem_wdata),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  // writeback select: frozen once halted, bubble while an access is in flight
  always_comb begin
    write_reg_d = halted  ? write_reg_q
                : done    ? make_wr(S_AOK, icode, val_e, rd ? dmem_rdata : 64'd0, dst_e, dst_m)
                : timeout ? make_wr(S_ADR, icode, val_e, 64'd0, dst_e, dst_m)
                : (busy || start) ? WR_BUBBLE
                : make_wr(stat_in, icode, val_e, 64'd0, dst_e, dst_m);
    m_valm_d   = write_reg_q[WR_VALM+:64];
    m_dstm_d   = write_reg_q[WR_DSTM+:4];
    m_status_d = halted;
  end

  // writeback and forwarding registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      write_reg_q <= WR_BUBBLE;
      m_valm_q    <= '0;
      m_dstm_q    <= '0;
      m_status_q  <= 1'b0;
    end else begin
      write_reg_q <= write_reg_d;
      m_valm_q    <= m_valm_d;
      m_dstm_q    <= m_dstm_d;
      m_status_q  <= m_status_d;
    end

  assign write_reg = write_reg_q;
  assign m_valM    = m_valm_q;
  assign m_dstM    = m_dstm_q;
  assign m_status  = m_status_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of the M stage against hand-computed writeback values
module tb_memory_stage;

  logic clk = 1'b0;
  logic reset;
  logic [144:0] memory_reg;
  logic m_stall, dmem_req, dmem_we, dmem_ack, m_status;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata, m_valM;
  logic [3:0] m_dstM;
  logic [141:0] write_reg;
  int n_checks = 0;
  int n_err = 0;
  int st;

  localparam logic [141:0] BUB = {2'd0, 4'd1, 64'd0, 64'd0, 4'hf, 4'hf};

  memory_stage #(.ADDR_LIMIT(4096), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .memory_reg(memory_reg), .m_stall(m_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .m_valM(m_valM), .m_dstM(m_dstM),
    .m_status(m_status), .write_reg(write_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [144:0] mr(input logic b, input logic [3:0] ic, input logic [63:0] ve,
                                      input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    return {b, ic, 4'h0, ve, va, de, dm};
  endfunction

  function automatic logic [141:0] wr(input logic [1:0] s, input logic [3:0] ic, input logic [63:0] ve,
                                      input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
    return {s, ic, ve, vm, de, dm};
  endfunction

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    memory_reg = mr(0, 4'd1, 0, 0, 4'hf, 4'hf);
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    #2;
    chk("rst_wr", write_reg, BUB);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", m_stall, 0);
    chk("rst_status", m_status, 0);
    chk("rst_valm", m_valM, 0);
    tick;
    reset = 1'b0;
    tick;

    // OPq passes straight through
    memory_reg = mr(0, 4'd6, 64'd7, 0, 4'd2, 4'hf);
    #1;
    chk("opq_stall", m_stall, 0);
    tick;
    chk("opq_wr", write_reg, wr(0, 6, 7, 0, 2, 15));
    chk("opq_req", dmem_req, 0);

    // mrmovq with ack one cycle after the request
    memory_reg = mr(0, 4'd5, 64'h40, 0, 4'hf, 4'd3);
    #1;
    chk("mr_stall_idle", m_stall, 1);
    tick;
    chk("mr_req", dmem_req, 1);
    chk("mr_we", dmem_we, 0);
    chk("mr_addr", dmem_addr, 64'h40);
    chk("mr_wr_bubble", write_reg, BUB);
    dmem_ack = 1'b1;
    dmem_rdata = 64'h1234;
    #1;
    chk("mr_stall_ack", m_stall, 0);
    tick;
    dmem_ack = 1'b0;
    memory_reg = mr(0, 4'd1, 0, 0, 4'hf, 4'hf);
    chk("mr_wr", write_reg, wr(0, 5, 64'h40, 64'h1234, 15, 3));
    chk("mr_req_drop", dmem_req, 0);
    tick;
    chk("mr_m_valm", m_valM, 64'h1234);
    chk("mr_m_dstm", m_dstM, 4'd3);

    // rmmovq with ack in the fourth waiting cycle
    memory_reg = mr(0, 4'd4, 64'h100, 64'hDEAD, 4'hf, 4'hf);
    #1;
    st = 0;
    for (int i = 0; i < 4; i++) begin
      st += int'(m_stall);
      tick;
    end
    chk("rm_req", dmem_req, 1);
    chk("rm_we", dmem_we, 1);
    chk("rm_addr", dmem_addr, 64'h100);
    chk("rm_wdata", dmem_wdata, 64'hDEAD);
    dmem_ack = 1'b1;
    dmem_rdata = 64'hFFFF;
    #1;
    st += int'(m_stall);
    tick;
    dmem_ack = 1'b0;
    memory_reg = mr(0, 4'd1, 0, 0, 4'hf, 4'hf);
    chk("rm_stall_cycles", st, 4);
    chk("rm_wr", write_reg, wr(0, 4, 64'h100, 0, 15, 15));

    // ret reads through valA
    memory_reg = mr(0, 4'd9, 64'h999, 64'h80, 4'hf, 4'hf);
    tick;
    chk("ret_addr", dmem_addr, 64'h80);
    chk("ret_we", dmem_we, 0);
    dmem_ack = 1'b1;
    dmem_rdata = 64'hABC;
    tick;
    dmem_ack = 1'b0;
    memory_reg = mr(0, 4'd1, 0, 0, 4'hf, 4'hf);
    chk("ret_wr", write_reg, wr(0, 9, 64'h999, 64'hABC, 15, 15));

    // highest in-range address still goes to memory
    memory_reg = mr(0, 4'd5, 64'd4088, 0, 4'hf, 4'd1);
    #1;
    chk("edge_stall", m_stall, 1);
    tick;
    dmem_ack = 1'b1;
    dmem_rdata = 64'h55;
    tick;
    dmem_ack = 1'b0;
    memory_reg = mr(0, 4'd1, 0, 0, 4'hf, 4'hf);
    chk("edge_wr", write_reg, wr(0, 5, 64'd4088, 64'h55, 15, 1));

    // out-of-range read freezes the stage
    memory_reg = mr(0, 4'd5, 64'd4090, 0, 4'hf, 4'hf);
    #1;
    chk("oor_stall", m_stall, 0);
    tick;
    chk("oor_req", dmem_req, 0);
    chk("oor_wr", write_reg, wr(2, 5, 64'd4090, 0, 15, 15));
    memory_reg = mr(0, 4'd6, 64'd7, 0, 4'd2, 4'hf);
    tick;
    chk("oor_status", m_status, 1);
    chk("oor_hold", write_reg, wr(2, 5, 64'd4090, 0, 15, 15));
    chk("oor_stall2", m_stall, 0);
    reset = 1'b1;
    #1;
    chk("oor_rst_wr", write_reg, BUB);
    tick;
    reset = 1'b0;

    // bad instruction and halt
    memory_reg = mr(1, 4'd5, 64'h40, 0, 4'hf, 4'd2);
    #1;
    chk("ins_stall", m_stall, 0);
    tick;
    chk("ins_wr", write_reg, wr(3, 5, 64'h40, 0, 15, 2));
    chk("ins_req", dmem_req, 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    memory_reg = mr(0, 4'd0, 0, 0, 4'hf, 4'hf);
    tick;
    chk("hlt_wr", write_reg, wr(1, 0, 0, 0, 15, 15));
    reset = 1'b1;
    tick;
    reset = 1'b0;

    // pushq with no ack times out after exactly 15 request cycles
    memory_reg = mr(0, 4'd10, 64'h200, 64'h77, 4'hf, 4'hf);
    tick;
    st = 0;
    for (int i = 0; i < 40 && dmem_req; i++) begin
      st++;
      tick;
    end
    chk("to_req_cycles", st, 15);
    chk("to_wr", write_reg, wr(2, 10, 64'h200, 0, 15, 15));
    chk("to_stall", m_stall, 0);
    tick;
    chk("to_frozen_req", dmem_req, 0);
    chk("to_status", m_status, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;

    // reset during WAIT, then a late ack
    memory_reg = mr(0, 4'd5, 64'h40, 0, 4'hf, 4'd3);
    tick;
    tick;
    tick;
    chk("rw_req_before", dmem_req, 1);
    reset = 1'b1;
    #1;
    chk("rw_req_async", dmem_req, 0);
    chk("rw_wr", write_reg, BUB);
    memory_reg = mr(0, 4'd1, 0, 0, 4'hf, 4'hf);
    tick;
    reset = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 64'h999;
    tick;
    dmem_ack = 1'b0;
    chk("rw_late_req", dmem_req, 0);
    chk("rw_late_wr", write_reg, wr(0, 1, 0, 0, 15, 15));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
